// File: rtl/rds_pkg.sv
// Shared constants, FSM encoding and offset helper for the RDS message updater.
package rds_pkg;
    localparam logic [7:0]  c_cmd_write   = 8'hA5;
    localparam int unsigned c_bank_bit    = 9;
    localparam int unsigned c_max_msg_len = 512;

    typedef logic [c_bank_bit-1:0] off_t;
    typedef logic [c_bank_bit:0]   mem_addr_t;

    typedef enum logic [2:0] {
        IDLE,
        ADDR_HI,
        ADDR_LO,
        LEN,
        DATA,
        PEND,
        SYNC
    } state_t;

    function automatic off_t start_offset(input off_t start, input int unsigned len);
        return off_t'(32'(start) % len);
    endfunction
endpackage

// File: rtl/rds_wrap_detect.sv
// Registers the modulator read address and flags the last->first message wrap; one-cycle pulse, combinational on rds_addr.
// No backpressure: pure observer of the modulator address.
module rds_wrap_detect
    import rds_pkg::*;
#(
    parameter int unsigned c_rds_msg_len = 260
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [8:0] rds_addr,
    output logic       wrap
);
    localparam off_t c_last = off_t'(c_rds_msg_len - 1);

    off_t rds_addr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rds_addr_q <= '0;
        end else begin
            rds_addr_q <= rds_addr;
        end
    end

    assign wrap = (rds_addr_q == c_last) && (rds_addr == '0);
endmodule

// File: rtl/rds_msg_updater.sv
// Host frames fill the shadow message bank; the bank swap lands on a message wrap, then the new active bank is copied into the shadow.
// Host writes appear one cycle after acceptance; s_ready is held low while waiting for the wrap and during the copy.
module rds_msg_updater
    import rds_pkg::*;
#(
    parameter int unsigned c_rds_msg_len = 260,
    parameter logic [7:0]  c_cmd_write   = rds_pkg::c_cmd_write
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    output logic       s_ready,
    input  logic [8:0] rds_addr,
    output logic       rd_bank,
    output logic [9:0] mem_addr,
    output logic [7:0] mem_wdata,
    output logic       mem_we,
    input  logic [7:0] mem_rdata,
    output logic       busy,
    output logic       err
);
    localparam off_t       c_last      = off_t'(c_rds_msg_len - 1);
    localparam logic [9:0] c_copy_last = 10'(2 * c_rds_msg_len - 1);

    state_t     state, state_nx;
    logic       ready_en;
    logic       xfer;
    logic       wrap;
    logic       start_msb;
    off_t       ptr;
    logic [7:0] len_q;
    logic [7:0] cnt;
    logic [9:0] copy_cnt;
    mem_addr_t  wr_addr_q;
    logic [7:0] wr_data_q;
    logic       wr_we_q;
    logic       err_q;
    logic       bank_q;

    rds_wrap_detect #(
        .c_rds_msg_len(c_rds_msg_len)
    ) u_wrap_detect (
        .clk     (clk),
        .rst_n   (rst_n),
        .rds_addr(rds_addr),
        .wrap    (wrap)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        s_ready  = 1'b0;
        case (state)
            IDLE, ADDR_HI, ADDR_LO, LEN, DATA: s_ready = ready_en;
            default:                           s_ready = 1'b0;
        endcase
        xfer = s_valid && s_ready;
        case (state)
            IDLE:    if (xfer && (s_data == c_cmd_write)) state_nx = ADDR_HI;
            ADDR_HI: if (xfer) state_nx = ADDR_LO;
            ADDR_LO: if (xfer) state_nx = LEN;
            LEN:     if (xfer) state_nx = DATA;
            DATA:    if (xfer && (cnt == len_q)) state_nx = PEND;
            PEND:    if (wrap) state_nx = SYNC;
            SYNC:    if (copy_cnt == c_copy_last) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en  <= 1'b0;
            start_msb <= 1'b0;
            ptr       <= '0;
            len_q     <= '0;
            cnt       <= '0;
            copy_cnt  <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_we_q   <= 1'b0;
            err_q     <= 1'b0;
            bank_q    <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            wr_we_q  <= 1'b0;
            err_q    <= (state == IDLE) && xfer && (s_data != c_cmd_write);
            case (state)
                ADDR_HI: if (xfer) start_msb <= s_data[0];
                ADDR_LO: if (xfer) ptr <= start_offset({start_msb, s_data}, c_rds_msg_len);
                LEN: begin
                    if (xfer) begin
                        len_q <= s_data;
                        cnt   <= '0;
                    end
                end
                DATA: begin
                    if (xfer) begin
                        wr_we_q   <= 1'b1;
                        wr_addr_q <= {~bank_q, ptr};
                        wr_data_q <= s_data;
                        ptr       <= (ptr == c_last) ? '0 : ptr + 1'b1;
                        cnt       <= cnt + 1'b1;
                    end
                end
                PEND: begin
                    if (wrap) begin
                        bank_q   <= ~bank_q;
                        copy_cnt <= '0;
                    end
                end
                SYNC:    copy_cnt <= copy_cnt + 1'b1;
                default: ;
            endcase
        end
    end

    // Copy alternates a read of the active bank with a write of the shadow bank at the same offset.
    always_comb begin
        mem_addr  = wr_addr_q;
        mem_we    = wr_we_q;
        mem_wdata = wr_data_q;
        if (state == SYNC) begin
            mem_addr  = {copy_cnt[0] ? ~bank_q : bank_q, copy_cnt[9:1]};
            mem_we    = copy_cnt[0];
            mem_wdata = copy_cnt[0] ? mem_rdata : 8'h00;
        end
    end

    assign rd_bank = bank_q;
    assign busy    = (state != IDLE);
    assign err     = err_q;
endmodule
